frame_link_arbiter: RTL and testbench

- Shares one byte-framed slave link between N_REQ requesters.
- Link protocol: cs low for exactly 3 consecutive clocks carrying header byte, payload[15:8], payload[7:0]. The slave answers with a 1-cycle ack (with 16-bit result) or err.
- Block arbitrates round-robin, serialises the granted frame, waits for the response with timeout, retries on err, and returns status/result to the requester.

---
 rtl/frame_link_arbiter.sv | 102 ++++++++++
 tb/tb_frame_link_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_link_arbiter.sv
// frame_link_arbiter: shares a 3-byte framed slave link between N_REQ requesters with timeout/retry.
// Define ARB_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module frame_link_arbiter #(
   parameter int N_REQ     = 4,
   parameter int MAX_RETRY = 2,
   parameter int TIMEOUT   = 16,
   parameter int GAP       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req,
   input  logic [8*N_REQ-1:0]    hdr,
   input  logic [16*N_REQ-1:0]   payload,
   output logic [N_REQ-1:0]      grant,
   output logic [N_REQ-1:0]      done,
   output logic                  fail,
   output logic [15:0]           rsp,
   output logic                  cs,
   output logic [7:0]            d_link,
   input  logic                  s_ack,
   input  logic                  s_err,
   input  logic [15:0]           s_dout
);
   localparam int IW = $clog2(N_REQ);
   typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_WAIT, S_FIN, S_GAP} state_t;
   state_t state, nxt;
   logic [IW-1:0] own, win, base;
   logic [7:0] hdr_q, tcnt;
   logic [15:0] pay_q, rsp_q;
   logic [2:0] retry;
   logic [3:0] gcnt;
   logic fail_q, hit, retry_ok, expired;
`ifdef ARB_FIXED_PRIORITY_EN
   assign base = '0;
`else
   logic [IW-1:0] ptr;
   assign base = ptr;
   always_ff @(posedge clk or negedge rst)
      if (!rst) ptr <= '0;
      else if (state == S_FIN) ptr <= (own == IW'(N_REQ-1)) ? '0 : own + 1'b1;
`endif
   // scanning downwards lets the nearest set bit after base overwrite the farther ones
   always_comb begin
      win = '0;
      for (int k = N_REQ-1; k >= 0; k--)
         if (req[(int'(base) + k) % N_REQ]) win = IW'((int'(base) + k) % N_REQ);
      hit = |req;
   end
   assign retry_ok = retry < 3'(MAX_RETRY);
   assign expired  = s_err || tcnt == 8'(TIMEOUT-1);
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  nxt = hit ? S_B0 : S_IDLE;
         S_B0:    nxt = S_B1;
         S_B1:    nxt = S_B2;
         S_B2:    nxt = S_WAIT;
         S_WAIT:  nxt = s_ack ? S_FIN : expired ? (retry_ok ? S_GAP : S_FIN) : S_WAIT;
         S_FIN:   nxt = S_GAP;
         S_GAP:   nxt = (gcnt == 4'd1) ? ((retry != 3'd0) ? S_B0 : S_IDLE) : S_GAP;
         default: nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         grant  <= '0;
         own    <= '0;
         hdr_q  <= '0;
         pay_q  <= '0;
         rsp_q  <= '0;
         fail_q <= 1'b0;
         retry  <= '0;
         tcnt   <= '0;
         gcnt   <= 4'(GAP);
      end else begin
         state <= nxt;
         tcnt  <= (state == S_WAIT) ? tcnt + 8'd1 : 8'd0;
         gcnt  <= (state == S_GAP) ? gcnt - 4'd1 : 4'(GAP);
         if (state == S_IDLE && hit) begin
            grant <= N_REQ'(1) << win;
            own   <= win;
            hdr_q <= hdr[8*int'(win) +: 8];
            pay_q <= payload[16*int'(win) +: 16];
         end
         if (state == S_WAIT && nxt == S_FIN) begin
            fail_q <= !s_ack;
            rsp_q  <= s_ack ? s_dout : 16'd0;
         end
         if (state == S_WAIT && nxt == S_GAP) retry <= retry + 3'd1;
         if (state == S_FIN) begin
            retry <= '0;
            grant <= '0;
         end
      end
   end
   assign cs     = !(state inside {S_B0, S_B1, S_B2});
   assign d_link = (state == S_B0) ? hdr_q : (state == S_B1) ? pay_q[15:8] : (state == S_B2) ? pay_q[7:0] : 8'd0;
   assign done   = (state == S_FIN) ? grant : '0;
   assign fail   = (state == S_FIN) && fail_q;
   assign rsp    = (state == S_FIN && !fail_q) ? rsp_q : 16'd0;
endmodule

// File: tb/tb_frame_link_arbiter.sv
// tb_frame_link_arbiter: randomized requesters and slave, transaction-level model and done scoreboard.
module tb_frame_link_arbiter;
   localparam int N = 4, MR = 2, TO = 16, GP = 2;
   logic clk = 0, rst = 0;
   logic [N-1:0] req = '0;
   logic [8*N-1:0] hdr_v = '0;
   logic [16*N-1:0] pay_v = '0;
   logic [N-1:0] grant, done;
   logic fail, cs, s_ack = 0, s_err = 0;
   logic [15:0] rsp, s_dout = '0;
   logic [7:0] d_link;

   frame_link_arbiter #(.N_REQ(N), .MAX_RETRY(MR), .TIMEOUT(TO), .GAP(GP)) dut (
      .clk(clk), .rst(rst), .req(req), .hdr(hdr_v), .payload(pay_v),
      .grant(grant), .done(done), .fail(fail), .rsp(rsp), .cs(cs), .d_link(d_link),
      .s_ack(s_ack), .s_err(s_err), .s_dout(s_dout));

   always #5 clk = ~clk;

   typedef struct {int own; bit fl; logic [15:0] r;} exp_t;
   exp_t sb[$];
   exp_t me;
   int own_log[$], gap_log[$];
   int checks = 0, failures = 0, nframes = 0, mode = 0, stray_idle = 0;
   logic [7:0] last_b[3];
   logic [15:0] ack_data = '0;
   logic [N-1:0] req_s = '0, busy = '0;
   bit hold_all = 0, rand_en = 0;

   task automatic check(input bit ok, input string nm, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) req_s <= req;

   // slave + link monitor + reference model: owner chosen from the pending set, outcome from attempt history
   int blen = 0, high = 0, att = 0, own = 0, ptr = 0, rcnt = 0, rkind = 0, rk = 0, stray_seen = 0;
   bit had = 0, rpend = 0, pend = 0;
   logic [15:0] rdata = '0;
   logic [7:0] b[3];
   always @(negedge clk) begin
      s_ack = 0;
      s_err = 0;
      if (!rst) begin
         blen = 0; high = 0; att = 0; ptr = 0; had = 0; rpend = 0; pend = 0;
      end else if (!cs) begin
         if (blen == 0) begin
            if (had) check(high >= GP, "gap", high, GP);
            gap_log.push_back(high);
            had = 1;
            high = 0;
            if (!rpend) begin
               own = -1;
               for (int k = N-1; k >= 0; k--) if (req_s[(ptr+k)%N]) own = (ptr+k)%N;
               check(own >= 0, "spurious_frame", req_s, 0);
               if (own < 0) own = 0;
               own_log.push_back(own);
            end
            check(grant == (N'(1) << own), "grant", grant, N'(1) << own);
         end
         check(blen < 3, "frame_len", blen + 1, 3);
         if (blen < 3) b[blen] = d_link;
         blen++;
         if (blen == 2 && mode == 0 && $urandom_range(0, 3) == 0) begin
            s_ack = 1;
            s_dout = 16'($urandom);
         end
         if (blen == 3) begin
            last_b = b;
            nframes++;
            check({b[0], b[1], b[2]} == {hdr_v[8*own +: 8], pay_v[16*own +: 16]}, "frame_bytes",
                  {b[0], b[1], b[2]}, {hdr_v[8*own +: 8], pay_v[16*own +: 16]});
            case (mode)
               1: rk = 0;
               2: rk = 2;
               3: rk = (att == 0) ? 1 : 0;
               default: begin
                  rk = $urandom_range(0, 9);
                  rk = (rk < 5) ? 0 : (rk < 6) ? 3 : (rk < 8) ? 1 : 2;
               end
            endcase
            rdata = (mode == 0) ? 16'($urandom) : ack_data;
            rcnt = (mode == 0) ? $urandom_range(0, 4) : 2;
            rkind = rk;
            pend = (rk != 2);
            if (rk == 0 || rk == 3 || att >= MR) begin
               sb.push_back('{own, (rk == 1 || rk == 2), (rk == 0 || rk == 3) ? rdata : 16'h0});
               att = 0;
               rpend = 0;
`ifdef ARB_FIXED_PRIORITY_EN
               ptr = 0;
`else
               ptr = (own + 1) % N;
`endif
            end else begin
               att++;
               rpend = 1;
            end
         end
      end else begin
         check(d_link == 0, "d_link_idle", d_link, 0);
         if (blen != 0) check(blen == 3, "frame_len", blen, 3);
         blen = 0;
         high++;
         if (stray_idle != stray_seen) begin
            stray_seen = stray_idle;
            s_ack = 1;
            s_dout = 16'hBEEF;
         end
         if (pend) begin
            if (rcnt == 0) begin
               pend = 0;
               s_dout = rdata;
               s_ack = (rkind == 0 || rkind == 3);
               s_err = (rkind == 1 || rkind == 3);
            end else rcnt--;
         end
      end
   end

   always @(negedge clk) if (rst) begin
      if (done != 0) begin
         check(sb.size() > 0, "unexpected_done", done, 0);
         if (sb.size() > 0) begin
            me = sb.pop_front();
            check(done == (N'(1) << me.own), "done_owner", done, N'(1) << me.own);
            check(fail == me.fl, "fail", fail, me.fl);
            check(rsp == me.r, "rsp", rsp, me.r);
         end
      end else check(rsp == 0 && fail == 0, "rsp_idle", rsp, 0);
   end

   task automatic raise(input int i, input logic [7:0] h, input logic [15:0] p);
      hdr_v[8*i +: 8] = h;
      pay_v[16*i +: 16] = p;
      req[i] = 1;
      busy[i] = 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
         if (done[i]) begin
            busy[i] = 0;
            req[i] = 0;
         end
         if (!busy[i] && (hold_all || (rand_en && $urandom_range(0, 3) == 0)))
            raise(i, 8'($urandom), 16'($urandom));
         else if (rand_en && grant[i] && req[i] && $urandom_range(0, 15) == 0)
            req[i] = 0;
      end
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (busy != 0 && n < 3000) begin
         tick();
         n++;
      end
      check(busy == 0, nm, busy, 0);
      repeat (4) tick();
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, g0, o0, n;
      int ord[5];
`ifdef ARB_FIXED_PRIORITY_EN
      ord = '{0, 0, 0, 0, 0};
`else
      ord = '{0, 1, 2, 3, 0};
`endif
      repeat (3) @(posedge clk);
      #1;
      check(grant == 0 && done == 0, "reset_grant_done", {grant, done}, 0);
      check(cs == 1 && d_link == 0, "reset_link", {cs, d_link}, 9'h100);
      check(fail == 0 && rsp == 0, "reset_rsp", {fail, rsp}, 0);
      @(negedge clk) rst = 1;

      mode = 1;
      ack_data = 16'h5A5A;
      hold_all = 1;
      n = 0;
      while (own_log.size() < 5 && n < 2000) begin
         tick();
         n++;
      end
      hold_all = 0;
      check(own_log.size() >= 5, "contention_count", own_log.size(), 5);
      if (own_log.size() >= 5) for (int k = 0; k < 5; k++) check(own_log[k] == ord[k], "contention_order", own_log[k], ord[k]);
      drain("contention_drain");

      ack_data = 16'h1234;
      f0 = nframes;
      raise(0, 8'hCA, 16'hFF01);
      drain("single_drain");
      check(nframes - f0 == 1, "single_frames", nframes - f0, 1);
      check({last_b[0], last_b[1], last_b[2]} == 24'hCAFF01, "single_bytes", {last_b[0], last_b[1], last_b[2]}, 24'hCAFF01);

      mode = 3;
      f0 = nframes;
      raise(1, 8'h3C, 16'hA55A);
      drain("retry_drain");
      check(nframes - f0 == 2, "retry_frames", nframes - f0, 2);

      mode = 2;
      f0 = nframes;
      g0 = gap_log.size();
      raise(2, 8'h77, 16'h0F0F);
      drain("exhaust_drain");
      check(nframes - f0 == MR + 1, "exhaust_frames", nframes - f0, MR + 1);
      if (gap_log.size() >= g0 + MR + 1)
         for (int k = 1; k <= MR; k++)
            check(gap_log[g0+k] >= TO + GP - 1 && gap_log[g0+k] <= TO + GP + 1, "exhaust_wait", gap_log[g0+k], TO + GP);

      mode = 1;
      f0 = nframes;
      for (int k = 0; k < 3; k++) begin
         stray_idle++;
         repeat (3) tick();
         check(cs == 1 && grant == 0 && rsp == 0, "stray_idle", {cs, grant, rsp}, 21'h100000);
      end
      check(nframes == f0, "stray_frames", nframes - f0, 0);

      mode = 0;
      rand_en = 1;
      repeat (3000) tick();
      rand_en = 0;
      drain("random_drain");

      mode = 1;
      raise(1, 8'h11, 16'h2233);
      drain("pre_reset_drain");
      raise(1, 8'h44, 16'h5566);
      raise(3, 8'h77, 16'h8899);
      n = 0;
      @(negedge clk);
      while (cs && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(!cs, "reset_frame_start", cs, 0);
      @(negedge clk);
      rst = 0;
      #1;
      check(cs == 1 && grant == 0 && d_link == 0, "async_reset", {cs, grant, d_link}, 13'h1000);
      o0 = own_log.size();
      repeat (2) @(negedge clk);
      rst = 1;
      drain("post_reset_drain");
      check(own_log.size() > o0, "post_reset_frame", own_log.size() - o0, 1);
      if (own_log.size() > o0) check(own_log[o0] == 1, "post_reset_owner", own_log[o0], 1);
      check(sb.size() == 0, "scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
